cdc_tx_ctrl: RTL and testbench



---
 rtl/cdc_ctrl_pkg.sv | 25 ++
 rtl/cdc_tx_ctrl_sync_ff.sv | 29 ++
 rtl/cdc_tx_ctrl.sv | 126 ++++++++++++
 tb/tb_cdc_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_ctrl_pkg.sv
// Shared types and defaults for the source-side CDC request/ack sequencer.
// Imported by cdc_tx_ctrl and its helpers.
package cdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    GAP
  } cdc_tx_state_t;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_SYNC_STG  = 2;
  localparam int DEF_GAP_CYC   = 2;
  localparam int DEF_TO_CYC    = 255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cdc_tx_ctrl_sync_ff.sv
// Single-bit multi-stage synchronizer for the toggled acknowledge.
// Output is the last stage of the shift chain.
module sync_ff #(
  parameter int STG = 2
) (
  input  logic CP,
  input  logic CLR,
  input  logic d,
  output logic q
);

  logic [STG-1:0] sh_q;
  logic [STG-1:0] sh_d;

  always_comb begin
    sh_d = {sh_q[STG-2:0], d};
  end

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q[STG-1];

endmodule

// File: rtl/cdc_tx_ctrl.sv
// Source-side sequencer: holds a word on TX_DATA, toggles TX_REQ after
// a settle time, then waits for the synchronized toggled acknowledge.
module cdc_tx_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int DW        = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int SYNC_STG  = DEF_SYNC_STG,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int TO_CYC    = DEF_TO_CYC
) (
  input  logic          CP,
  input  logic          CLR,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic [DW-1:0] S_DATA,
  output logic [DW-1:0] TX_DATA,
  output logic          TX_REQ,
  input  logic          RX_ACK,
  input  logic          ERR_CLR,
  output logic          BUSY,
  output logic          TO_ERR
);

  localparam int CMAX = max3(SETUP_CYC, GAP_CYC, TO_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] TO_MAX     = CW'(TO_CYC);
  localparam logic [CW-1:0] GAP_LAST   =
    CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  cdc_tx_state_t state_q;
  cdc_tx_state_t state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [DW-1:0] tx_data_q;
  logic [DW-1:0] tx_data_d;
  logic          tx_req_q;
  logic          tx_req_d;
  logic          to_err_q;
  logic          to_err_d;
  logic          to_set;
  logic          ack_sync;

  sync_ff #(
    .STG (SYNC_STG)
  ) u_ack_sync (
    .CP  (CP),
    .CLR (CLR),
    .d   (RX_ACK),
    .q   (ack_sync)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    to_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (S_VALID) begin
          tx_data_d = S_DATA;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          tx_req_d = ~tx_req_q;
          cnt_d    = '0;
          state_d  = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (ack_sync == tx_req_q) begin
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (cnt_q != TO_MAX) begin
          // flag only on the reaching edge so a later clear sticks
          cnt_d  = cnt_q + 1'b1;
          to_set = (cnt_q == TO_LAST);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    to_err_d = to_set | (to_err_q & ~ERR_CLR);
  end

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      to_err_q  <= to_err_d;
    end
  end

  assign S_READY = (state_q == IDLE);
  assign BUSY    = (state_q != IDLE);
  assign TX_DATA = tx_data_q;
  assign TX_REQ  = tx_req_q;
  assign TO_ERR  = to_err_q;

endmodule

// File: tb/tb_cdc_tx_ctrl.sv
// Directed bench for cdc_tx_ctrl: one instance with TO_CYC=16 and
// one with GAP_CYC=0, both sharing clock and reset.
module tb_cdc_tx_ctrl;

  logic       CP;
  logic       CLR;
  logic       S_VALID;
  logic       S_READY;
  logic [7:0] S_DATA;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       RX_ACK;
  logic       ERR_CLR;
  logic       BUSY;
  logic       TO_ERR;

  logic       v0;
  logic       rdy0;
  logic [7:0] d0;
  logic [7:0] txd0;
  logic       req0;
  logic       ack0;
  logic       eclr0;
  logic       busy0;
  logic       err0;

  int n_tot;
  int n_fail;

  cdc_tx_ctrl #(
    .DW        (8),
    .SETUP_CYC (2),
    .SYNC_STG  (2),
    .GAP_CYC   (2),
    .TO_CYC    (16)
  ) dut (
    .CP      (CP),
    .CLR     (CLR),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .S_DATA  (S_DATA),
    .TX_DATA (TX_DATA),
    .TX_REQ  (TX_REQ),
    .RX_ACK  (RX_ACK),
    .ERR_CLR (ERR_CLR),
    .BUSY    (BUSY),
    .TO_ERR  (TO_ERR)
  );

  cdc_tx_ctrl #(
    .DW        (8),
    .SETUP_CYC (2),
    .SYNC_STG  (2),
    .GAP_CYC   (0),
    .TO_CYC    (16)
  ) dut0 (
    .CP      (CP),
    .CLR     (CLR),
    .S_VALID (v0),
    .S_READY (rdy0),
    .S_DATA  (d0),
    .TX_DATA (txd0),
    .TX_REQ  (req0),
    .RX_ACK  (ack0),
    .ERR_CLR (eclr0),
    .BUSY    (busy0),
    .TO_ERR  (err0)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tot   = 0;
    n_fail  = 0;
    CLR     = 1'b1;
    S_VALID = 1'b0;
    S_DATA  = 8'h00;
    RX_ACK  = 1'b0;
    ERR_CLR = 1'b0;
    v0      = 1'b0;
    d0      = 8'h00;
    ack0    = 1'b0;
    eclr0   = 1'b0;
    ticks(2);
    CLR = 1'b0;

    chk("rst_ready", S_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_req", TX_REQ, 0);
    chk("rst_err", TO_ERR, 0);

    // single word; FF held valid during SETUP/WAIT/GAP must be ignored
    S_VALID = 1'b1;
    S_DATA  = 8'hA5;
    tick();
    chk("sw_data_e0", TX_DATA, 8'hA5);
    chk("sw_ready_e0", S_READY, 0);
    chk("sw_busy_e0", BUSY, 1);
    S_DATA = 8'hFF;
    tick();
    chk("sw_req_e1", TX_REQ, 0);
    tick();
    chk("sw_req_e2", TX_REQ, 1);
    chk("sw_data_e2", TX_DATA, 8'hA5);
    ticks(7);
    RX_ACK = 1'b1;
    ticks(2);
    chk("sw_busy_e11", BUSY, 1);
    ticks(2);
    chk("sw_ready_e13", S_READY, 0);
    chk("sw_data_e13", TX_DATA, 8'hA5);
    S_VALID = 1'b0;
    tick();
    chk("sw_ready_e14", S_READY, 1);
    chk("sw_busy_e14", BUSY, 0);
    chk("sw_err_e14", TO_ERR, 0);

    // back-to-back 0x11 then 0x22
    S_VALID = 1'b1;
    S_DATA  = 8'h11;
    tick();
    chk("bb_data_b0", TX_DATA, 8'h11);
    S_DATA = 8'h22;
    ticks(2);
    chk("bb_req_b2", TX_REQ, 0);
    chk("bb_data_b2", TX_DATA, 8'h11);
    RX_ACK = 1'b0;
    ticks(2);
    chk("bb_busy_b4", BUSY, 1);
    chk("bb_data_b4", TX_DATA, 8'h11);
    ticks(2);
    chk("bb_ready_b6", S_READY, 0);
    chk("bb_data_b6", TX_DATA, 8'h11);
    tick();
    chk("bb_ready_b7", S_READY, 1);
    chk("bb_data_b7", TX_DATA, 8'h11);
    tick();
    chk("bb_data_b8", TX_DATA, 8'h22);
    chk("bb_ready_b8", S_READY, 0);
    S_VALID = 1'b0;
    ticks(2);
    chk("bb_req_b10", TX_REQ, 1);

    // 0x22 gets no ack: timeout after 16 WAIT edges
    ticks(15);
    chk("to_err_w15", TO_ERR, 0);
    tick();
    chk("to_err_w16", TO_ERR, 1);
    chk("to_busy_w16", BUSY, 1);
    chk("to_req_w16", TX_REQ, 1);
    ticks(2);
    RX_ACK = 1'b1;
    ticks(3);
    chk("to_ready_late", S_READY, 0);
    ticks(2);
    chk("to_ready_done", S_READY, 1);
    chk("to_err_kept", TO_ERR, 1);
    chk("to_data_kept", TX_DATA, 8'h22);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("to_err_clr", TO_ERR, 0);

    // ERR_CLR on the setting edge loses to the set
    S_VALID = 1'b1;
    S_DATA  = 8'h33;
    tick();
    S_VALID = 1'b0;
    ticks(2);
    chk("tc_req_c2", TX_REQ, 0);
    ticks(15);
    chk("tc_err_c17", TO_ERR, 0);
    ERR_CLR = 1'b1;
    tick();
    chk("tc_err_c18", TO_ERR, 1);
    tick();
    chk("tc_err_c19", TO_ERR, 0);
    ERR_CLR = 1'b0;
    tick();
    chk("tc_err_c20", TO_ERR, 0);
    chk("tc_busy_c20", BUSY, 1);
    RX_ACK = 1'b0;
    ticks(5);
    chk("tc_ready_c25", S_READY, 1);
    chk("tc_data_c25", TX_DATA, 8'h33);

    // asynchronous reset mid-cycle with TX_REQ=1 pending
    S_VALID = 1'b1;
    S_DATA  = 8'h44;
    tick();
    S_VALID = 1'b0;
    ticks(2);
    chk("mr_req_pre", TX_REQ, 1);
    chk("mr_data_pre", TX_DATA, 8'h44);
    #3;
    CLR = 1'b1;
    #1;
    chk("mr_req", TX_REQ, 0);
    chk("mr_data", TX_DATA, 0);
    chk("mr_err", TO_ERR, 0);
    chk("mr_ready", S_READY, 1);
    chk("mr_busy", BUSY, 0);
    tick();
    CLR = 1'b0;

    // GAP_CYC=0 instance: ready returns at e+2
    v0 = 1'b1;
    d0 = 8'h5A;
    tick();
    v0 = 1'b0;
    chk("g0_data_g0", txd0, 8'h5A);
    ticks(3);
    chk("g0_req_g3", req0, 1);
    ack0 = 1'b1;
    ticks(2);
    chk("g0_ready_e1", rdy0, 0);
    tick();
    chk("g0_ready_e2", rdy0, 1);
    chk("g0_busy_e2", busy0, 0);
    chk("g0_data_e2", txd0, 8'h5A);
    chk("g0_err_e2", err0, 0);

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule
